// File: rtl/controle_navegacao.sv
// Left-hand wall-following sequencer: samples wall sensors, tracks heading, issues
// advance strobes and timed turn commands, counts steps and detects a blocked cell.
module controle_navegacao #(
  parameter int TEMPO_GIRO   = 4,
  parameter int TEMPO_AVANCO = 8,
  parameter int MAX_PASSOS   = 255,
  parameter int PASSOS_W     = 8
) (
  input  logic                c3,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                parar,
  input  logic                frente,
  input  logic                esquerda,
  output logic                avancar,
  output logic [0:2]          orientacao,
  output logic [0:1]          girar,
  output logic [PASSOS_W-1:0] passos,
  output logic                ocupado,
  output logic                fim,
  output logic                bloqueado
);

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    DECIDE   = 3'd1,
    GIRA_ESQ = 3'd2,
    GIRA_DIR = 3'd3,
    AVANCA   = 3'd4,
    ESPERA   = 3'd5,
    FIM      = 3'd6
  } estado_t;

  localparam logic [0:2] NORTE = 3'b001;
  localparam logic [0:2] OESTE = 3'b010;
  localparam logic [0:2] LESTE = 3'b011;
  localparam logic [0:2] SUL   = 3'b100;

  localparam logic [0:1] G_NADA = 2'b00;
  localparam logic [0:1] G_ESQ  = 2'b01;
  localparam logic [0:1] G_DIR  = 2'b10;

  // Timers count down to zero, so a hold of N cycles is loaded as N-1.
  localparam logic [7:0]          T_GIRO   = 8'(TEMPO_GIRO - 1);
  localparam logic [7:0]          T_AVANCO = 8'(TEMPO_AVANCO - 1);
  localparam logic [PASSOS_W-1:0] LIMITE   = PASSOS_W'(MAX_PASSOS);

  estado_t             estado, estado_n;
  logic [7:0]          timer, timer_n;
  logic [2:0]          nd, nd_n;
  logic [0:2]          orientacao_n;
  logic [0:1]          girar_n;
  logic                avancar_n, fim_n, bloqueado_n, ocupado_n;
  logic [PASSOS_W-1:0] passos_n;

  function automatic logic [0:2] gira_esq(input logic [0:2] o);
    case (o)
      NORTE:   gira_esq = OESTE;
      OESTE:   gira_esq = SUL;
      SUL:     gira_esq = LESTE;
      default: gira_esq = NORTE;
    endcase
  endfunction

  function automatic logic [0:2] gira_dir(input logic [0:2] o);
    case (o)
      NORTE:   gira_dir = LESTE;
      LESTE:   gira_dir = SUL;
      SUL:     gira_dir = OESTE;
      default: gira_dir = NORTE;
    endcase
  endfunction

  always_ff @(posedge c3 or negedge reset) begin
    if (!reset) begin
      estado     <= PARADO;
      orientacao <= NORTE;
      avancar    <= 1'b0;
      girar      <= G_NADA;
      passos     <= '0;
      fim        <= 1'b0;
      bloqueado  <= 1'b0;
      ocupado    <= 1'b0;
      timer      <= '0;
      nd         <= '0;
    end else begin
      estado     <= estado_n;
      orientacao <= orientacao_n;
      avancar    <= avancar_n;
      girar      <= girar_n;
      passos     <= passos_n;
      fim        <= fim_n;
      bloqueado  <= bloqueado_n;
      ocupado    <= ocupado_n;
      timer      <= timer_n;
      nd         <= nd_n;
    end
  end

  always_comb begin
    estado_n     = estado;
    orientacao_n = orientacao;
    avancar_n    = 1'b0;
    girar_n      = girar;
    passos_n     = passos;
    fim_n        = fim;
    bloqueado_n  = bloqueado;
    timer_n      = timer;
    nd_n         = nd;
    // Abort keeps heading and step count so the run can be inspected afterwards.
    if (parar) begin
      estado_n = PARADO;
      girar_n  = G_NADA;
      fim_n    = 1'b0;
    end else begin
      case (estado)
        PARADO: if (iniciar) begin
          estado_n    = DECIDE;
          passos_n    = '0;
          fim_n       = 1'b0;
          bloqueado_n = 1'b0;
          nd_n        = '0;
        end
        DECIDE: begin
          if (!esquerda) begin
            estado_n     = GIRA_ESQ;
            orientacao_n = gira_esq(orientacao);
            girar_n      = G_ESQ;
            timer_n      = T_GIRO;
          end else if (!frente) begin
            estado_n  = AVANCA;
            avancar_n = 1'b1;
          end else begin
            estado_n     = GIRA_DIR;
            orientacao_n = gira_dir(orientacao);
            girar_n      = G_DIR;
            nd_n         = nd + 3'd1;
            timer_n      = T_GIRO;
          end
        end
        // A left turn always commits to an advance, so the robot cannot spin left forever.
        GIRA_ESQ: begin
          if (timer == 8'd0) begin
            estado_n  = AVANCA;
            girar_n   = G_NADA;
            avancar_n = 1'b1;
          end else begin
            timer_n = timer - 8'd1;
          end
        end
        GIRA_DIR: begin
          if (timer == 8'd0) begin
            girar_n = G_NADA;
            if (nd == 3'd4) begin
              estado_n    = FIM;
              fim_n       = 1'b1;
              bloqueado_n = 1'b1;
            end else begin
              estado_n = DECIDE;
            end
          end else begin
            timer_n = timer - 8'd1;
          end
        end
        AVANCA: begin
          estado_n = ESPERA;
          passos_n = passos + PASSOS_W'(1);
          nd_n     = '0;
          timer_n  = T_AVANCO;
        end
        ESPERA: begin
          if (timer == 8'd0) begin
            if (passos == LIMITE) begin
              estado_n = FIM;
              fim_n    = 1'b1;
            end else begin
              estado_n = DECIDE;
            end
          end else begin
            timer_n = timer - 8'd1;
          end
        end
        FIM: if (!iniciar) begin
          estado_n = PARADO;
          fim_n    = 1'b0;
        end
        default: begin
          estado_n = PARADO;
          girar_n  = G_NADA;
          fim_n    = 1'b0;
        end
      endcase
    end
    ocupado_n = (estado_n != PARADO) && (estado_n != FIM);
  end

endmodule

// File: tb/tb_controle_navegacao.sv
// Bench for controle_navegacao: a segment-planning model predicts every output cycle,
// and directed scenarios pin timing, headings and end conditions with literal values.
module tb_controle_navegacao;

  localparam int TG   = 4;
  localparam int TA   = 8;
  localparam int MAXP = 3;
  localparam int PW   = 8;

  logic          c3 = 1'b0;
  logic          reset, iniciar, parar, frente, esquerda;
  logic          avancar, ocupado, fim, bloqueado;
  logic [0:2]    orientacao;
  logic [0:1]    girar;
  logic [PW-1:0] passos;

  int errors = 0;
  int checks = 0;

  controle_navegacao #(
    .TEMPO_GIRO(TG), .TEMPO_AVANCO(TA), .MAX_PASSOS(MAXP), .PASSOS_W(PW)
  ) dut (
    .c3(c3), .reset(reset), .iniciar(iniciar), .parar(parar), .frente(frente),
    .esquerda(esquerda), .avancar(avancar), .orientacao(orientacao), .girar(girar),
    .passos(passos), .ocupado(ocupado), .fim(fim), .bloqueado(bloqueado)
  );

  always #5 c3 = ~c3;

  typedef struct packed {
    logic       av;
    logic [2:0] ori;
    logic [1:0] gir;
    logic [7:0] pas;
    logic       ocu;
    logic       fim;
    logic       blq;
  } outs_t;

  typedef struct packed {
    outs_t      o;
    logic [1:0] tag;
  } ent_t;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_DEC  = 2'd1;
  localparam logic [1:0] T_FIM  = 2'd2;

  // Headings clockwise: N, L(east), S, O(west).
  logic [2:0] cod [4] = '{3'b001, 3'b011, 3'b100, 3'b010};
  int         m_h = 0;
  int         m_rc = 0;
  int         m_mode = 0;
  logic [7:0] m_pas = '0;
  logic       m_bq = 1'b0;
  ent_t       q[$];
  ent_t       cur = '0;

  function automatic ent_t mk(input logic av, input logic [1:0] gir, input logic ocu,
                              input logic fi, input logic [1:0] tag);
    ent_t e;
    e.o   = {av, cod[m_h], gir, m_pas, ocu, fi, m_bq};
    e.tag = tag;
    return e;
  endfunction

  task automatic plan_avanco();
    q.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, T_NONE));
    m_pas = m_pas + 8'd1;
    m_rc  = 0;
    repeat (TA) q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, T_NONE));
    if (int'(m_pas) == MAXP) q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, T_FIM));
    else                     q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, T_DEC));
  endtask

  task automatic plan();
    if (!esquerda) begin
      m_h = (m_h + 3) % 4;
      repeat (TG) q.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, T_NONE));
      plan_avanco();
    end else if (!frente) begin
      plan_avanco();
    end else begin
      m_h  = (m_h + 1) % 4;
      m_rc = m_rc + 1;
      repeat (TG) q.push_back(mk(1'b0, 2'b10, 1'b1, 1'b0, T_NONE));
      if (m_rc == 4) begin
        m_bq = 1'b1;
        q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, T_FIM));
      end else begin
        q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, T_DEC));
      end
    end
  endtask

  always @(posedge c3 or negedge reset) begin
    if (!reset) begin
      m_h = 0; m_pas = '0; m_rc = 0; m_bq = 1'b0; m_mode = 0;
      q.delete();
      cur = mk(1'b0, 2'b00, 1'b0, 1'b0, T_NONE);
    end else if (parar) begin
      q.delete();
      m_mode = 0;
      cur = mk(1'b0, 2'b00, 1'b0, 1'b0, T_NONE);
    end else if (m_mode == 0) begin
      if (iniciar) begin
        m_pas = '0; m_bq = 1'b0; m_rc = 0; m_mode = 1;
        cur = mk(1'b0, 2'b00, 1'b1, 1'b0, T_DEC);
      end
    end else if (m_mode == 2) begin
      if (!iniciar) begin
        m_mode = 0;
        cur = mk(1'b0, 2'b00, 1'b0, 1'b0, T_NONE);
      end
    end else begin
      if (cur.tag == T_DEC) plan();
      if (q.size() > 0) cur = q.pop_front();
      if (cur.tag == T_FIM) m_mode = 2;
    end
  end

  always @(negedge c3) begin
    outs_t act;
    act = {avancar, orientacao, girar, passos, ocupado, fim, bloqueado};
    checks++;
    if (act !== cur.o) begin
      errors++;
      $display("FAIL cycle_model t=%0t: got av=%b ori=%b gir=%b pas=%0d ocu=%b fim=%b blq=%b expected av=%b ori=%b gir=%b pas=%0d ocu=%b fim=%b blq=%b",
               $time, act.av, act.ori, act.gir, act.pas, act.ocu, act.fim, act.blq,
               cur.o.av, cur.o.ori, cur.o.gir, cur.o.pas, cur.o.ocu, cur.o.fim, cur.o.blq);
    end
  end

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [2:0] dirs_exp [4] = '{3'b011, 3'b100, 3'b010, 3'b001};
  logic [2:0] dirs_got [4];

  initial begin
    int n, k, m, g, r;
    int t_av [3];
    logic prev;
    reset = 1'b0; iniciar = 1'b0; parar = 1'b0; frente = 1'b0; esquerda = 1'b0;
    repeat (3) @(negedge c3);
    chk("reset_ori", int'(orientacao), 1);
    chk("reset_ocupado", int'(ocupado), 0);
    reset = 1'b1;
    @(negedge c3);

    // Open corridor until the step limit.
    esquerda = 1'b1; frente = 1'b0; iniciar = 1'b1;
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      @(negedge c3); n++;
      if (avancar) begin
        t_av[k] = n;
        chk("corr_passos_at_pulse", int'(passos), k);
        chk("corr_ori", int'(orientacao), 1);
        k++;
      end
    end
    chk("corr_pulses", k, 3);
    chk("corr_period1", t_av[1] - t_av[0], 2 + TA);
    chk("corr_period2", t_av[2] - t_av[1], 2 + TA);
    m = 0;
    while (!fim && m < 50) begin @(negedge c3); m++; end
    chk("limit_fim_delay", m, 1 + TA);
    chk("limit_passos", int'(passos), 3);
    chk("limit_bloq", int'(bloqueado), 0);
    chk("limit_ocupado", int'(ocupado), 0);
    iniciar = 1'b0;
    @(negedge c3);
    chk("limit_release_fim", int'(fim), 0);
    chk("limit_release_ocupado", int'(ocupado), 0);

    // Left opening while heading north.
    esquerda = 1'b0; frente = 1'b0; iniciar = 1'b1;
    n = 0;
    while (girar != 2'b01 && n < 20) begin @(negedge c3); n++; end
    chk("left_girar", int'(girar), 1);
    chk("left_ori", int'(orientacao), 2);
    g = 0;
    while (girar == 2'b01 && g < 20) begin g++; @(negedge c3); end
    chk("left_cycles", g, TG);
    chk("left_avancar", int'(avancar), 1);
    @(negedge c3);
    chk("left_avancar_done", int'(avancar), 0);
    chk("left_passos", int'(passos), 1);
    esquerda = 1'b1;
    parar = 1'b1;
    @(negedge c3);
    chk("left_parar_ocupado", int'(ocupado), 0);
    parar = 1'b0; iniciar = 1'b0;

    // Dead end from north.
    reset = 1'b0;
    @(negedge c3);
    reset = 1'b1;
    frente = 1'b1; esquerda = 1'b1; iniciar = 1'b1;
    n = 0; r = 0; g = 0; prev = 1'b0;
    while (!fim && n < 100) begin
      @(negedge c3); n++;
      if (girar == 2'b10) begin
        g++;
        if (!prev && r < 4) begin dirs_got[r] = orientacao; r++; end
      end
      prev = (girar == 2'b10);
    end
    chk("dead_turns", r, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("dead_ori%0d", i), int'(dirs_got[i]), int'(dirs_exp[i]));
    chk("dead_girar_cycles", g, 4 * TG);
    chk("dead_fim", int'(fim), 1);
    chk("dead_bloq", int'(bloqueado), 1);
    chk("dead_passos", int'(passos), 0);
    iniciar = 1'b0;
    @(negedge c3);

    // Abort in the middle of a right turn from north, with iniciar still high.
    iniciar = 1'b1;
    n = 0;
    while (girar != 2'b10 && n < 20) begin @(negedge c3); n++; end
    chk("abort_girar_seen", int'(girar), 2);
    @(negedge c3);
    parar = 1'b1;
    @(negedge c3);
    chk("abort_girar", int'(girar), 0);
    chk("abort_ori", int'(orientacao), 3);
    chk("abort_ocupado", int'(ocupado), 0);
    @(negedge c3);
    chk("abort_beats_iniciar", int'(ocupado), 0);
    parar = 1'b0; iniciar = 1'b0;
    @(negedge c3);

    // Asynchronous reset while settling after an advance.
    esquerda = 1'b1; frente = 1'b0; iniciar = 1'b1;
    n = 0;
    while (!avancar && n < 20) begin @(negedge c3); n++; end
    chk("areset_avancar_seen", int'(avancar), 1);
    @(negedge c3);
    @(negedge c3);
    chk("areset_pre_passos", int'(passos), 1);
    chk("areset_pre_ocupado", int'(ocupado), 1);
    @(posedge c3);
    #2 reset = 1'b0;
    #1;
    chk("areset_ori", int'(orientacao), 1);
    chk("areset_passos", int'(passos), 0);
    chk("areset_ocupado", int'(ocupado), 0);
    chk("areset_outs", int'({avancar, girar, fim, bloqueado}), 0);
    iniciar = 1'b0;
    @(negedge c3);
    reset = 1'b1;
    repeat (3) @(negedge c3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
